// File: rtl/pipe_adder_pkg.sv
// Shared segment-geometry helpers for the carry-split pipelined adder.
// Segment k covers bits [seg_lo(k) +: seg_w(k)]; the last segment takes the remainder.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 74;
    localparam int DEF_STAGES = 4;

    function automatic int seg_base_w(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int seg_lo(input int width, input int stages, input int k);
        return k * seg_base_w(width, stages);
    endfunction

    function automatic int last_seg_w(input int width, input int stages);
        return width - (stages - 1) * seg_base_w(width, stages);
    endfunction

    function automatic int seg_w(input int width, input int stages, input int k);
        return (k == stages - 1) ? last_seg_w(width, stages) : seg_base_w(width, stages);
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               (last_seg_w(width, stages) >= 1);
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// One carry-chain segment: adds its operand slice plus carry-in and registers
// the slice sum and carry-out when the pipeline advances.
module pipe_adder_seg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= total[W-1:0];
            cout <= total[W];
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Width-generic pipelined adder/subtractor with valid/ready handshakes.
// Optional signed-overflow output ovf is built when PIPE_ADDER_OVF_EN is defined.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LAST_W = last_seg_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES) || LAST_W < 1) begin : g_cfg_err
        $error("pipe_adder: WIDTH/STAGES leave an empty last segment");
    end

    logic                       adv;
    logic [STAGES:0][WIDTH-1:0] a_p;
    logic [STAGES:0][WIDTH-1:0] b_p;
    logic [STAGES:0][WIDTH-1:0] res_p;
    logic [STAGES:0]            c_p;
    logic [STAGES:0]            vld_p;

    // One enable for the whole pipe: a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0: operand capture; subtraction is folded into a + ~b + 1.
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             c_p0;
    logic             vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0   <= '0;
            b_p0   <= '0;
            c_p0   <= 1'b0;
            vld_p0 <= 1'b0;
        end else if (adv) begin
            a_p0   <= a;
            b_p0   <= b ^ {WIDTH{sub}};
            c_p0   <= sub;
            vld_p0 <= in_valid;
        end
    end

    assign a_p[0]   = a_p0;
    assign b_p[0]   = b_p0;
    assign c_p[0]   = c_p0;
    assign vld_p[0] = vld_p0;
    assign res_p[0] = '0;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam int LO = seg_lo(WIDTH, STAGES, k - 1);
        localparam int SW = seg_w(WIDTH, STAGES, k - 1);

        logic [SW-1:0]    seg_sum;
        logic             seg_cout;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] skew_q;
        logic             vld_q;
        logic [WIDTH-1:0] res_k;

        pipe_adder_seg #(.W(SW)) u_seg (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (adv),
            .a    (a_p[k-1][LO +: SW]),
            .b    (b_p[k-1][LO +: SW]),
            .cin  (c_p[k-1]),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        // Stage k: carry operands and already-finished low sum bits alongside the segment add.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q    <= '0;
                b_q    <= '0;
                skew_q <= '0;
                vld_q  <= 1'b0;
            end else if (adv) begin
                a_q    <= a_p[k-1];
                b_q    <= b_p[k-1];
                skew_q <= res_p[k-1];
                vld_q  <= vld_p[k-1];
            end
        end

        always_comb begin
            res_k            = skew_q;
            res_k[LO +: SW]  = seg_sum;
        end

        assign a_p[k]   = a_q;
        assign b_p[k]   = b_q;
        assign c_p[k]   = seg_cout;
        assign vld_p[k] = vld_q;
        assign res_p[k] = res_k;
    end

    assign out_valid = vld_p[STAGES];
    assign sum       = {c_p[STAGES], res_p[STAGES]};

    logic unused_operands;
    assign unused_operands = ^{a_p[STAGES], b_p[STAGES]};

`ifdef PIPE_ADDER_OVF_EN
    // Carry into the MSB recovered from the registered MSB operand bits and sum bit.
    assign ovf = a_p[STAGES][WIDTH-1] ^ b_p[STAGES][WIDTH-1] ^
                 res_p[STAGES][WIDTH-1] ^ c_p[STAGES];
`endif

endmodule
